mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameters: none; widths SHALL come from cpu_types_pkg (word_t = 32 bits, regbits_t = 5 bits).
REQ-002 Clocking: one clock, CLK; reset nRST is asynchronous and active-low.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 nRST  in  1  asynchronous active-low reset.
REQ-005 en  in  1  MEM/WB latch enable; 0 = downstream freeze.
REQ-006 sRST  in  1  synchronous flush of the FSM and the MEM/WB latch.
REQ-007 porto_l  in  32  latched ALU result; memory address for loads and stores.
REQ-008 rdat2_l  in  32  latched store data.
REQ-009 wsel_l  in  5  latched destination register.
REQ-010 regen_l, hlt_l, dmemREN_l, dmemWEN_l  in  1 each  latched control bits.
REQ-011 regsrc_l  in  2  writeback select.
REQ-012 dhit  in  1  data-memory request complete.
REQ-013 dmemload  in  32  read data, valid when dhit=1.
REQ-014 dmemREN, dmemWEN  out  1 each  data-memory request strobes.
REQ-015 dmemaddr  out  32  memory address, equal to {porto_l[31:2],2'b00}.
REQ-016 dmemstore  out  32  store data, equal to rdat2_l.
REQ-017 mem_stall  out  1  freeze for PC, IF/ID, ID/EX and EX/MEM.
REQ-018 wb_wdat  out  32  registered writeback data.
REQ-019 wb_wsel  out  5  registered writeback register.
REQ-020 wb_regen, wb_hlt  out  1 each  registered MEM/WB control.
REQ-021 halt  out  1  sticky halt.

Function
REQ-022 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-023 IDLE, no memory op (dmemREN_l=dmemWEN_l=0): mem_stall=0, strobes=0, MEM/WB latch captures on the edge when en=1.
REQ-024 IDLE, memory op present and halt=0: mem_stall=1, strobes=0, next state ACCESS.
REQ-025 ACCESS: dmemWEN=dmemWEN_l and dmemREN=dmemREN_l&~dmemWEN_l (write wins), mem_stall=1; addr, data and strobes held stable until dhit.
REQ-026 ACCESS with dhit=1: capture dmemload into an internal load buffer, next state DONE; dhit=0 remains in ACCESS with no timeout.
REQ-027 DONE: strobes=0, mem_stall=0, MEM/WB latch captures when en=1, then go to IDLE; en=0 holds DONE and keeps mem_stall=1 so the access is never reissued.
REQ-028 wb_wdat selection: regsrc_l=2'b01 gives the load buffer; 2'b00, 2'b10 and 2'b11 give porto_l.
REQ-029 Latency: non-memory op 0 stall cycles; memory op 1 (IDLE) + N (ACCESS until dhit) + 0 (DONE) stall cycles, with writeback on the DONE edge.
REQ-030 wb_hlt captures hlt_l; halt sets when a captured hlt_l=1 and stays set until nRST.
REQ-031 While halt=1: no new strobes, mem_stall=0, MEM/WB latch captures only bubbles (wb_regen=0).
REQ-032 sRST=1 (synchronous, highest priority after nRST): FSM to IDLE, strobes drop the same cycle, load buffer and all wb_* outputs cleared; halt is not cleared.
REQ-033 dhit outside ACCESS SHALL be ignored.
REQ-034 Strobes SHALL never be asserted in two consecutive cycles for one EX/MEM entry after dhit.

Reset
REQ-035 nRST=0 SHALL asynchronously force FSM=IDLE, load buffer=0, wb_wdat=0, wb_wsel=0, wb_regen=0, wb_hlt=0 and halt=0.
REQ-036 During nRST=0, dmemREN, dmemWEN and mem_stall SHALL read 0; this includes reset asserted mid-ACCESS.

Verification
REQ-037 ALU op: porto_l=32'h0000_0010, regsrc=00, wsel=5, regen=1 -> next edge wb_wdat=32'h10, wb_wsel=5, wb_regen=1, and mem_stall never asserted.
REQ-038 Load: porto_l=32'h0000_0107, dmemREN_l=1, regsrc=01, dhit after 3 ACCESS cycles with dmemload=32'hDEAD_BEEF -> dmemaddr=32'h104 throughout, mem_stall high for 4 cycles, wb_wdat=32'hDEADBEEF.
REQ-039 Store with dmemREN_l=dmemWEN_l=1: rdat2_l=32'h1234_5678 -> dmemWEN=1 and dmemREN=0 held until dhit, dmemstore=32'h12345678, exactly one request.
REQ-040 Load in ACCESS with sRST pulsed for 1 cycle -> strobes 0 on the same cycle, wb_* = 0, FSM=IDLE; a later dhit is ignored.
REQ-041 Load completes with en=0 for 2 cycles in DONE -> no reissue, mem_stall stays 1, and writeback occurs on the first edge with en=1.
REQ-042 hlt_l=1 captured, then a load presented -> halt=1, wb_hlt=1, dmemREN stays 0; halt persists until nRST=0.

Source files
------------

// File: rtl/mem_stage_ctrl_if.sv
// Shared CPU width types and the bundle connecting the MEM stage to the
// EX/MEM latch, the data memory and the MEM/WB latch consumers.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;
endpackage

interface mem_stage_if;
  import cpu_types_pkg::*;

  logic       en;
  logic       sRST;
  word_t      porto_l;
  word_t      rdat2_l;
  regbits_t   wsel_l;
  logic       regen_l;
  logic       hlt_l;
  logic       dmemREN_l;
  logic       dmemWEN_l;
  logic [1:0] regsrc_l;
  logic       dhit;
  word_t      dmemload;
  logic       dmemREN;
  logic       dmemWEN;
  word_t      dmemaddr;
  word_t      dmemstore;
  logic       mem_stall;
  word_t      wb_wdat;
  regbits_t   wb_wsel;
  logic       wb_regen;
  logic       wb_hlt;
  logic       halt;

  // The MEM stage controller is the master of the data-memory request.
  modport master (
    input  en, sRST, porto_l, rdat2_l, wsel_l, regen_l, hlt_l,
           dmemREN_l, dmemWEN_l, regsrc_l, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
           wb_wdat, wb_wsel, wb_regen, wb_hlt, halt
  );

  modport slave (
    output en, sRST, porto_l, rdat2_l, wsel_l, regen_l, hlt_l,
           dmemREN_l, dmemWEN_l, regsrc_l, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
           wb_wdat, wb_wsel, wb_regen, wb_hlt, halt
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: sequences one data-memory access per EX/MEM entry,
// stalls the upstream pipeline while it is outstanding, and owns MEM/WB.
module mem_stage_ctrl
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  mem_stage_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_nextState;
  word_t      r_loadBuf;
  word_t      r_wbWdat;
  regbits_t   r_wbWsel;
  logic       r_wbRegen;
  logic       r_wbHlt;
  logic       r_halt;

  logic       w_memOp;
  logic       w_inAccess;
  logic       w_stallRaw;
  logic       w_capture;
  word_t      w_wdatSel;

  assign w_memOp   = bus.dmemREN_l | bus.dmemWEN_l;
  assign w_wdatSel = (bus.regsrc_l == 2'b01) ? r_loadBuf : bus.porto_l;

  // Strobes exist only in ACCESS and vanish immediately on either reset.
  assign w_inAccess   = (r_state == ACCESS) & nRST & ~bus.sRST;
  assign bus.dmemWEN  = w_inAccess & bus.dmemWEN_l;
  assign bus.dmemREN  = w_inAccess & bus.dmemREN_l & ~bus.dmemWEN_l;
  assign bus.dmemaddr = {bus.porto_l[31:2], 2'b00};
  assign bus.dmemstore = bus.rdat2_l;

  always_comb begin
    w_stallRaw = 1'b0;
    case (r_state)
      IDLE:    w_stallRaw = w_memOp & ~r_halt;
      ACCESS:  w_stallRaw = 1'b1;
      DONE:    w_stallRaw = ~bus.en;
      default: w_stallRaw = 1'b0;
    endcase
  end

  assign bus.mem_stall = w_stallRaw & nRST & ~bus.sRST;

  // MEM/WB advances whenever the stage is not holding the pipeline for memory.
  assign w_capture = bus.en &
                     (((r_state == IDLE) & (~w_memOp | r_halt)) | (r_state == DONE));

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_memOp && !r_halt) w_nextState = ACCESS;
      ACCESS:  if (bus.dhit)           w_nextState = DONE;
      DONE:    if (bus.en)             w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_loadBuf <= '0;
    end else if (bus.sRST) begin
      r_state   <= IDLE;
      r_loadBuf <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ACCESS && bus.dhit)
        r_loadBuf <= bus.dmemload;
    end
  end

  // Once halted only bubbles retire; they keep the halt marker visible in WB.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wbWdat  <= '0;
      r_wbWsel  <= '0;
      r_wbRegen <= 1'b0;
      r_wbHlt   <= 1'b0;
      r_halt    <= 1'b0;
    end else if (bus.sRST) begin
      r_wbWdat  <= '0;
      r_wbWsel  <= '0;
      r_wbRegen <= 1'b0;
      r_wbHlt   <= 1'b0;
    end else if (w_capture) begin
      if (r_halt) begin
        r_wbWdat  <= '0;
        r_wbWsel  <= '0;
        r_wbRegen <= 1'b0;
        r_wbHlt   <= 1'b1;
      end else begin
        r_wbWdat  <= w_wdatSel;
        r_wbWsel  <= bus.wsel_l;
        r_wbRegen <= bus.regen_l;
        r_wbHlt   <= bus.hlt_l;
        if (bus.hlt_l)
          r_halt <= 1'b1;
      end
    end
  end

  assign bus.wb_wdat  = r_wbWdat;
  assign bus.wb_wsel  = r_wbWsel;
  assign bus.wb_regen = r_wbRegen;
  assign bus.wb_hlt   = r_wbHlt;
  assign bus.halt     = r_halt;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a transaction-level model checked every
// cycle, plus literal expectations for the key load/store/flush/halt cases.
module tb_mem_stage_ctrl;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  int   checks = 0;
  int   errors = 0;
  int   stallCnt = 0;
  int   reqCnt = 0;
  int   strobeCnt = 0;
  logic prevStrobe = 1'b0;

  mem_stage_if bus();

  mem_stage_ctrl dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Model: is a request on the bus, has data come back awaiting retirement.
  logic     mIssued = 1'b0;
  logic     mReady  = 1'b0;
  logic     mHalt   = 1'b0;
  word_t    mLoad   = '0;
  word_t    mWdat   = '0;
  regbits_t mWsel   = '0;
  logic     mRegen  = 1'b0;
  logic     mHltW   = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input word_t porto, input word_t rdat2,
                               input regbits_t wsel, input logic regen,
                               input logic hlt, input logic ren, input logic wen,
                               input logic [1:0] regsrc);
    bus.porto_l   = porto;
    bus.rdat2_l   = rdat2;
    bus.wsel_l    = wsel;
    bus.regen_l   = regen;
    bus.hlt_l     = hlt;
    bus.dmemREN_l = ren;
    bus.dmemWEN_l = wen;
    bus.regsrc_l  = regsrc;
  endtask

  task automatic nop();
    applyStimulus(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    logic memOp, quiet, expStrobe, expRen, expWen, expStall, retire, oldHalt;
    memOp = bus.dmemREN_l | bus.dmemWEN_l;
    quiet = !mIssued && !mReady;
    if (!nRST) begin
      mIssued = 1'b0; mReady = 1'b0; mHalt = 1'b0; mLoad = '0;
      mWdat = '0; mWsel = '0; mRegen = 1'b0; mHltW = 1'b0;
      expRen = 1'b0; expWen = 1'b0; expStall = 1'b0;
    end else begin
      expStrobe = mIssued && !bus.sRST;
      expWen    = expStrobe && bus.dmemWEN_l;
      expRen    = expStrobe && bus.dmemREN_l && !bus.dmemWEN_l;
      expStall  = !bus.sRST &&
                  (mIssued || (mReady && !bus.en) || (quiet && memOp && !mHalt));
    end
    checkOutput("cyc_ren",    32'(bus.dmemREN),   32'(expRen));
    checkOutput("cyc_wen",    32'(bus.dmemWEN),   32'(expWen));
    checkOutput("cyc_stall",  32'(bus.mem_stall), 32'(expStall));
    checkOutput("cyc_addr",   bus.dmemaddr, {bus.porto_l[31:2], 2'b00});
    checkOutput("cyc_store",  bus.dmemstore, bus.rdat2_l);
    checkOutput("cyc_wdat",   bus.wb_wdat, mWdat);
    checkOutput("cyc_wsel",   32'(bus.wb_wsel),  32'(mWsel));
    checkOutput("cyc_regen",  32'(bus.wb_regen), 32'(mRegen));
    checkOutput("cyc_wbhlt",  32'(bus.wb_hlt),   32'(mHltW));
    checkOutput("cyc_halt",   32'(bus.halt),     32'(mHalt));

    if (bus.mem_stall) stallCnt++;
    if (bus.dmemREN || bus.dmemWEN) strobeCnt++;
    if ((bus.dmemREN || bus.dmemWEN) && !prevStrobe) reqCnt++;
    prevStrobe = bus.dmemREN || bus.dmemWEN;

    if (nRST) begin
      retire  = bus.en && (mReady || (quiet && (!memOp || mHalt)));
      oldHalt = mHalt;
      if (bus.sRST) begin
        mIssued = 1'b0; mReady = 1'b0; mLoad = '0;
        mWdat = '0; mWsel = '0; mRegen = 1'b0; mHltW = 1'b0;
      end else begin
        if (retire) begin
          if (oldHalt) begin
            mWdat = '0; mWsel = '0; mRegen = 1'b0; mHltW = 1'b1;
          end else begin
            mWdat  = (bus.regsrc_l == 2'b01) ? mLoad : bus.porto_l;
            mWsel  = bus.wsel_l;
            mRegen = bus.regen_l;
            mHltW  = bus.hlt_l;
            if (bus.hlt_l) mHalt = 1'b1;
          end
          mReady = 1'b0;
        end
        if (mIssued && bus.dhit) begin
          mIssued = 1'b0;
          mReady  = 1'b1;
          mLoad   = bus.dmemload;
        end else if (quiet && memOp && !oldHalt) begin
          mIssued = 1'b1;
        end
      end
    end
  end

  initial begin
    nRST = 1'b0;
    bus.en = 1'b1;
    bus.sRST = 1'b0;
    bus.dhit = 1'b0;
    bus.dmemload = '0;
    applyStimulus(32'h0000_0108, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
    tick();
    tick();
    checkOutput("rst_stall", 32'(bus.mem_stall), 32'h0);
    checkOutput("rst_wdat",  bus.wb_wdat, 32'h0);
    checkOutput("rst_halt",  32'(bus.halt), 32'h0);
    nop();
    nRST = 1'b1;
    tick();

    $display("[TB] ALU op");
    stallCnt = 0;
    applyStimulus(32'h0000_0010, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    tick();
    checkOutput("alu_wdat",  bus.wb_wdat, 32'h0000_0010);
    checkOutput("alu_wsel",  32'(bus.wb_wsel), 32'd5);
    checkOutput("alu_regen", 32'(bus.wb_regen), 32'd1);
    checkOutput("alu_stall", 32'(stallCnt), 32'd0);
    nop();
    bus.dhit = 1'b1;
    bus.dmemload = 32'hBAD0_BAD0;
    tick();
    bus.dhit = 1'b0;

    $display("[TB] load with three access cycles");
    stallCnt = 0;
    reqCnt = 0;
    applyStimulus(32'h0000_0107, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
    tick();
    checkOutput("load_addr", bus.dmemaddr, 32'h0000_0104);
    checkOutput("load_ren",  32'(bus.dmemREN), 32'd1);
    tick();
    tick();
    bus.dhit = 1'b1;
    bus.dmemload = 32'hDEAD_BEEF;
    tick();
    bus.dhit = 1'b0;
    checkOutput("load_done_stall", 32'(bus.mem_stall), 32'd0);
    tick();
    nop();
    checkOutput("load_wdat",   bus.wb_wdat, 32'hDEAD_BEEF);
    checkOutput("load_wsel",   32'(bus.wb_wsel), 32'd7);
    checkOutput("load_stalls", 32'(stallCnt), 32'd4);
    checkOutput("load_reqs",   32'(reqCnt), 32'd1);
    tick();

    $display("[TB] store with both strobes requested");
    reqCnt = 0;
    strobeCnt = 0;
    applyStimulus(32'h0000_0200, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    tick();
    checkOutput("store_wen",  32'(bus.dmemWEN), 32'd1);
    checkOutput("store_ren",  32'(bus.dmemREN), 32'd0);
    checkOutput("store_data", bus.dmemstore, 32'h1234_5678);
    tick();
    bus.dhit = 1'b1;
    bus.dmemload = 32'h1111_1111;
    tick();
    bus.dhit = 1'b0;
    tick();
    checkOutput("store_reqs",    32'(reqCnt), 32'd1);
    checkOutput("store_strobes", 32'(strobeCnt), 32'd2);
    checkOutput("store_wdat",    bus.wb_wdat, 32'h0000_0200);

    $display("[TB] flush during access");
    applyStimulus(32'h0000_0300, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
    tick();
    tick();
    bus.sRST = 1'b1;
    #1;
    checkOutput("srst_ren_now", 32'(bus.dmemREN), 32'd0);
    tick();
    bus.sRST = 1'b0;
    nop();
    checkOutput("srst_wdat",  bus.wb_wdat, 32'h0);
    checkOutput("srst_regen", 32'(bus.wb_regen), 32'd0);
    checkOutput("srst_stall", 32'(bus.mem_stall), 32'd0);
    bus.dhit = 1'b1;
    bus.dmemload = 32'h5555_AAAA;
    tick();
    bus.dhit = 1'b0;
    checkOutput("srst_late_dhit", bus.wb_wdat, 32'h0);
    tick();

    $display("[TB] load completing into a frozen writeback");
    reqCnt = 0;
    applyStimulus(32'h0000_0040, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
    tick();
    bus.dhit = 1'b1;
    bus.dmemload = 32'hCAFE_F00D;
    tick();
    bus.dhit = 1'b0;
    bus.en = 1'b0;
    #1;
    checkOutput("frz_stall1", 32'(bus.mem_stall), 32'd1);
    tick();
    checkOutput("frz_stall2", 32'(bus.mem_stall), 32'd1);
    checkOutput("frz_ren",    32'(bus.dmemREN), 32'd0);
    checkOutput("frz_wsel",   32'(bus.wb_wsel), 32'd0);
    tick();
    bus.en = 1'b1;
    #1;
    checkOutput("frz_release", 32'(bus.mem_stall), 32'd0);
    tick();
    nop();
    checkOutput("frz_wdat", bus.wb_wdat, 32'hCAFE_F00D);
    checkOutput("frz_wsel_wb", 32'(bus.wb_wsel), 32'd9);
    checkOutput("frz_reqs", 32'(reqCnt), 32'd1);
    tick();

    $display("[TB] halt then load");
    reqCnt = 0;
    applyStimulus(32'h0000_0055, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    tick();
    checkOutput("hlt_halt",  32'(bus.halt), 32'd1);
    checkOutput("hlt_wbhlt", 32'(bus.wb_hlt), 32'd1);
    checkOutput("hlt_wdat",  bus.wb_wdat, 32'h0000_0055);
    applyStimulus(32'h0000_0080, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
    tick();
    checkOutput("hlt_ren",   32'(bus.dmemREN), 32'd0);
    checkOutput("hlt_stall", 32'(bus.mem_stall), 32'd0);
    tick();
    tick();
    checkOutput("hlt_bubble_regen", 32'(bus.wb_regen), 32'd0);
    checkOutput("hlt_bubble_wbhlt", 32'(bus.wb_hlt), 32'd1);
    checkOutput("hlt_reqs", 32'(reqCnt), 32'd0);
    bus.sRST = 1'b1;
    tick();
    bus.sRST = 1'b0;
    checkOutput("hlt_after_srst", 32'(bus.halt), 32'd1);
    tick();
    nRST = 1'b0;
    #1;
    checkOutput("hlt_cleared", 32'(bus.halt), 32'd0);
    tick();
    nop();
    nRST = 1'b1;
    tick();

    $display("[TB] reset during access");
    applyStimulus(32'h0000_0090, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
    tick();
    tick();
    checkOutput("arst_ren_before", 32'(bus.dmemREN), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    checkOutput("arst_ren",   32'(bus.dmemREN), 32'd0);
    checkOutput("arst_stall", 32'(bus.mem_stall), 32'd0);
    tick();
    nop();
    nRST = 1'b1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
